// File: rtl/ccu_pack_dispatch_ctrl_if.sv
// Payload output stream from the CCU pack dispatcher to its NUM_DEST consumers.
interface ccu_pack_dispatch_ctrl_if #(
  parameter int unsigned NUM_DEST = 4
);
  localparam int unsigned DW = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;

  logic [7:0]          out_data;
  logic [DW-1:0]       out_dest;
  logic                out_valid;
  logic                out_last;
  logic [NUM_DEST-1:0] out_ready;

  // Dispatcher side drives the payload, consumers drive per-destination ready.
  modport master (
    output out_data,
    output out_dest,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_dest,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/ccu_pack_dispatch_ctrl.sv
// Packet sequencer: routes header-announced payload bytes through a FWFT FIFO to one
// consumer, checks the XOR trailer and reports per-packet done/error status.
module ccu_pack_dispatch_ctrl #(
  parameter int unsigned NUM_DEST       = 4,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned MAX_LENGTH     = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hdr_valid,
  input  logic [15:0] hdr_pack_id,
  input  logic [7:0]  hdr_pack_type,
  input  logic [15:0] hdr_pack_length,
  input  logic [7:0]  recv_data,
  input  logic        recv_en,
  ccu_pack_dispatch_ctrl_if.master out_if,
  output logic        busy,
  output logic [15:0] cur_pack_id,
  output logic        int_pack_done,
  output logic        int_pack_error,
  output logic [2:0]  err_code,
  output logic [15:0] pack_count
);

  localparam int unsigned DW = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_TYPE     = 3'd1;
  localparam logic [2:0] ERR_LENGTH   = 3'd2;
  localparam logic [2:0] ERR_OVERFLOW = 3'd3;
  localparam logic [2:0] ERR_CHECKSUM = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAYLOAD,
    S_DROP,
    S_CHECKSUM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  logic [15:0]   pack_len;
  logic [15:0]   byte_cnt;
  logic [7:0]    xor_acc;
  logic [DW-1:0] dest_q;
  logic [TW-1:0] tmo_cnt;

  logic [8:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [8:0]    rd_entry;

  logic fifo_empty_c;
  logic fifo_full_c;
  logic pop_c;
  logic push_req_c;
  logic push_c;
  logic ovf_c;
  logic last_byte_c;
  logic counting_c;
  logic tmo_hit_c;
  logic [15:0] len_m1_c;

  // FIFO status, handshake and per-cycle strobes derived from registered state.
  always_comb begin
    fifo_empty_c = (wr_ptr == rd_ptr);
    fifo_full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop_c        = !fifo_empty_c && out_if.out_ready[dest_q];
    push_req_c   = recv_en && (state == S_PAYLOAD);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_c       = push_req_c && (!fifo_full_c || pop_c);
    ovf_c        = push_req_c && fifo_full_c && !pop_c;
    len_m1_c     = pack_len - 16'd1;
    last_byte_c  = (byte_cnt == len_m1_c);
    counting_c   = (state == S_PAYLOAD) || (state == S_DROP) || (state == S_CHECKSUM);
    tmo_hit_c    = counting_c && !recv_en && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    rd_entry     = fifo_mem[rd_ptr[AW-1:0]];
  end

  assign out_if.out_valid = !fifo_empty_c;
  assign out_if.out_data  = rd_entry[7:0];
  assign out_if.out_last  = rd_entry[8];
  assign out_if.out_dest  = dest_q;
  assign busy             = (state != S_IDLE);

  // Payload storage; each entry carries the byte and its end-of-packet flag.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_mem[wr_ptr[AW-1:0]] <= {last_byte_c, recv_data};
    end
  end

  // FIFO pointers; a timeout discards everything still queued.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (tmo_hit_c) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Packet sequencer: header decode, byte counting, trailer check, status reporting.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= S_IDLE;
      pack_len       <= '0;
      byte_cnt       <= '0;
      xor_acc        <= '0;
      dest_q         <= '0;
      tmo_cnt        <= '0;
      cur_pack_id    <= '0;
      int_pack_done  <= 1'b0;
      int_pack_error <= 1'b0;
      err_code       <= ERR_NONE;
      pack_count     <= '0;
    end else begin
      int_pack_done  <= 1'b0;
      int_pack_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hdr_valid) begin
            cur_pack_id <= hdr_pack_id;
            pack_len    <= hdr_pack_length;
            dest_q      <= DW'(hdr_pack_type);
            err_code    <= ERR_NONE;
            byte_cnt    <= '0;
            xor_acc     <= '0;
            tmo_cnt     <= '0;
            if (hdr_pack_length > 16'(MAX_LENGTH)) begin
              err_code <= ERR_LENGTH;
              state    <= S_DONE;
            end else if ({1'b0, hdr_pack_type} >= 9'(NUM_DEST)) begin
              err_code <= ERR_TYPE;
              // An empty bad-type packet has nothing to drop, only the trailer.
              state    <= (hdr_pack_length == 16'd0) ? S_CHECKSUM : S_DROP;
            end else if (hdr_pack_length == 16'd0) begin
              state <= S_CHECKSUM;
            end else begin
              state <= S_PAYLOAD;
            end
          end
        end

        S_PAYLOAD, S_DROP: begin
          if (recv_en) begin
            xor_acc  <= xor_acc ^ recv_data;
            byte_cnt <= byte_cnt + 16'd1;
            tmo_cnt  <= '0;
            if (ovf_c && (err_code == ERR_NONE)) err_code <= ERR_OVERFLOW;
            if (last_byte_c) state <= S_CHECKSUM;
          end else if (tmo_hit_c) begin
            // The first recorded error is the one reported.
            if (err_code == ERR_NONE) err_code <= ERR_TIMEOUT;
            state <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        S_CHECKSUM: begin
          if (recv_en) begin
            if ((recv_data != xor_acc) && (err_code == ERR_NONE)) err_code <= ERR_CHECKSUM;
            tmo_cnt <= '0;
            state   <= S_DRAIN;
          end else if (tmo_hit_c) begin
            if (err_code == ERR_NONE) err_code <= ERR_TIMEOUT;
            state <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        S_DRAIN: begin
          // Consumer stalls are tolerated indefinitely here.
          if (fifo_empty_c) state <= S_DONE;
        end

        S_DONE: begin
          int_pack_done <= 1'b1;
          if (err_code != ERR_NONE) begin
            int_pack_error <= 1'b1;
          end else begin
            pack_count <= pack_count + 16'd1;
          end
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
